// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: opcodes, ALU ops,
// datapath mux selects, FSM states and the bundled control-word struct.
package rv_ctrl_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLL = 3'd3;

   localparam logic [1:0] ASEL_RS1   = 2'd0;
   localparam logic [1:0] ASEL_PC    = 2'd1;
   localparam logic [1:0] ASEL_OLDPC = 2'd2;
   localparam logic [1:0] BSEL_RS2   = 2'd0;
   localparam logic [1:0] BSEL_IMM   = 2'd1;
   localparam logic [1:0] BSEL_FOUR  = 2'd2;

   localparam logic ADDR_PC      = 1'b0;
   localparam logic ADDR_ALUOUT  = 1'b1;
   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd7
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic       pc_src;
      logic       oldpc_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic       reg_write;
      logic       mem_to_reg;
      logic       retire;
      logic       trap;
   } ctrl_t;

   function automatic logic is_legal_opcode(input logic [6:0] opc);
      return (opc == OP) || (opc == OPIMM) || (opc == LOAD) ||
             (opc == STORE) || (opc == BRANCH);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle. master = sequencer, slave = datapath side.
interface multicycle_control_if;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        ir_write;
   logic        mdr_write;
   logic        pc_write;
   logic        pc_src;
   logic        oldpc_write;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctrl;
   logic        reg_write;
   logic        mem_to_reg;
   logic        retire;
   logic        trap;
   logic [2:0]  state;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
             oldpc_write, alu_src_a, alu_src_b, alu_ctrl, reg_write, mem_to_reg,
             retire, trap, state
   );

   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
             oldpc_write, alu_src_a, alu_src_b, alu_ctrl, reg_write, mem_to_reg,
             retire, trap, state
   );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts stalled memory-request cycles; expired_o flags the cycle in which the
// count reaches MEM_TIMEOUT with no ready, so the FSM can trap on the next edge.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic active_i,
   input  logic ready_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (active_i && !ready_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Ready in the final allowed cycle wins over the timeout.
   assign expired_o = active_i && !ready_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for add/xor/sll/addi/lw/sw/bne. Outputs are pure decode
// of state + IR fields; only the state and the memory wait counter are registered.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);

   state_t     state_q;
   state_t     state_d;
   ctrl_t      ctl;
   ctrl_t      ctl_g;
   logic       tmr_clear;
   logic       tmr_expired;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_instr_bits;

   assign opcode            = bus.instr[6:0];
   assign funct3            = bus.instr[14:12];
   assign unused_instr_bits = ^{bus.instr[31:15], bus.instr[11:7]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ctl     = '0;
      state_d = state_q;
      case (state_q)
         FETCH: begin
            ctl.mem_req     = 1'b1;
            ctl.addr_sel    = ADDR_PC;
            ctl.alu_src_a   = ASEL_PC;
            ctl.alu_src_b   = BSEL_FOUR;
            ctl.alu_ctrl    = ALU_ADD;
            ctl.oldpc_write = 1'b1;
            if (bus.mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               ctl.pc_src   = PCSRC_ALU;
               state_d      = DECODE;
            end else if (tmr_expired) begin
               state_d = TRAP;
            end
         end
         DECODE: begin
            // Branch target OldPC+imm lands in ALUOut for EXEC to use.
            ctl.alu_src_a = ASEL_OLDPC;
            ctl.alu_src_b = BSEL_IMM;
            ctl.alu_ctrl  = ALU_ADD;
            if (!is_legal_opcode(opcode)) begin
               state_d = TRAP;
            end else if ((opcode == BRANCH) && (funct3 != 3'b001)) begin
               state_d = TRAP;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            case (opcode)
               OP: begin
                  ctl.alu_src_a = ASEL_RS1;
                  ctl.alu_src_b = BSEL_RS2;
                  state_d       = WB;
                  case (funct3)
                     3'b000:  ctl.alu_ctrl = ALU_ADD;
                     3'b100:  ctl.alu_ctrl = ALU_XOR;
                     3'b001:  ctl.alu_ctrl = ALU_SLL;
                     default: state_d      = TRAP;
                  endcase
               end
               OPIMM, LOAD, STORE: begin
                  ctl.alu_src_a = ASEL_RS1;
                  ctl.alu_src_b = BSEL_IMM;
                  ctl.alu_ctrl  = ALU_ADD;
                  state_d       = (opcode == OPIMM) ? WB : MEM;
               end
               BRANCH: begin
                  ctl.alu_src_a = ASEL_RS1;
                  ctl.alu_src_b = BSEL_RS2;
                  ctl.alu_ctrl  = ALU_SUB;
                  ctl.retire    = 1'b1;
                  if (!bus.zero) begin
                     ctl.pc_write = 1'b1;
                     ctl.pc_src   = PCSRC_ALUOUT;
                  end
                  state_d = FETCH;
               end
               default: state_d = TRAP;
            endcase
         end
         MEM: begin
            ctl.mem_req  = 1'b1;
            ctl.addr_sel = ADDR_ALUOUT;
            ctl.mem_we   = (opcode == STORE);
            if (bus.mem_ready) begin
               if (opcode == LOAD) begin
                  ctl.mdr_write = 1'b1;
                  state_d       = WB;
               end else begin
                  ctl.retire = 1'b1;
                  state_d    = FETCH;
               end
            end else if (tmr_expired) begin
               state_d = TRAP;
            end
         end
         WB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = (opcode == LOAD);
            ctl.retire     = 1'b1;
            state_d        = FETCH;
         end
         TRAP: begin
            ctl.trap = 1'b1;
         end
         default: state_d = TRAP;
      endcase
   end

   assign tmr_clear = (state_d != state_q) && ((state_d == FETCH) || (state_d == MEM));

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (tmr_clear),
      .active_i  (ctl.mem_req),
      .ready_i   (bus.mem_ready),
      .expired_o (tmr_expired)
   );

   // Gating with rst_n kills a pending request the instant reset asserts.
   assign ctl_g = rst_n ? ctl : '0;

   assign bus.mem_req     = ctl_g.mem_req;
   assign bus.mem_we      = ctl_g.mem_we;
   assign bus.addr_sel    = ctl_g.addr_sel;
   assign bus.ir_write    = ctl_g.ir_write;
   assign bus.mdr_write   = ctl_g.mdr_write;
   assign bus.pc_write    = ctl_g.pc_write;
   assign bus.pc_src      = ctl_g.pc_src;
   assign bus.oldpc_write = ctl_g.oldpc_write;
   assign bus.alu_src_a   = ctl_g.alu_src_a;
   assign bus.alu_src_b   = ctl_g.alu_src_b;
   assign bus.alu_ctrl    = ctl_g.alu_ctrl;
   assign bus.reg_write   = ctl_g.reg_write;
   assign bus.mem_to_reg  = ctl_g.mem_to_reg;
   assign bus.retire      = ctl_g.retire;
   assign bus.trap        = ctl_g.trap;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4): per-cycle control-word
// vectors are hand-written and compared half a clock away from the rising edge.
module tb_multicycle_control;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   multicycle_control_if bus ();

   multicycle_control #(
      .MEM_TIMEOUT (4),
      .CNT_W       (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Word layout: {state[2:0], mem_req, mem_we, addr_sel, ir_write, mdr_write,
   // pc_write, pc_src, oldpc_write, alu_src_a[1:0], alu_src_b[1:0], alu_ctrl[2:0],
   // reg_write, mem_to_reg, retire, trap}
   localparam logic [21:0] F_RDY  = {3'd0, 8'b1001_0101, 2'd1, 2'd2, 3'd0, 4'b0000};
   localparam logic [21:0] F_WAIT = {3'd0, 8'b1000_0001, 2'd1, 2'd2, 3'd0, 4'b0000};
   localparam logic [21:0] DEC    = {3'd1, 8'b0000_0000, 2'd2, 2'd1, 3'd0, 4'b0000};
   localparam logic [21:0] EX_IMM = {3'd2, 8'b0000_0000, 2'd0, 2'd1, 3'd0, 4'b0000};
   localparam logic [21:0] EX_XOR = {3'd2, 8'b0000_0000, 2'd0, 2'd0, 3'd2, 4'b0000};
   localparam logic [21:0] EX_BT  = {3'd2, 8'b0000_0110, 2'd0, 2'd0, 3'd1, 4'b0010};
   localparam logic [21:0] EX_BN  = {3'd2, 8'b0000_0000, 2'd0, 2'd0, 3'd1, 4'b0010};
   localparam logic [21:0] M_WAIT = {3'd3, 8'b1010_0000, 2'd0, 2'd0, 3'd0, 4'b0000};
   localparam logic [21:0] M_LD   = {3'd3, 8'b1010_1000, 2'd0, 2'd0, 3'd0, 4'b0000};
   localparam logic [21:0] M_STW  = {3'd3, 8'b1110_0000, 2'd0, 2'd0, 3'd0, 4'b0000};
   localparam logic [21:0] M_ST   = {3'd3, 8'b1110_0000, 2'd0, 2'd0, 3'd0, 4'b0010};
   localparam logic [21:0] WB_ALU = {3'd4, 8'b0000_0000, 2'd0, 2'd0, 3'd0, 4'b1010};
   localparam logic [21:0] WB_LD  = {3'd4, 8'b0000_0000, 2'd0, 2'd0, 3'd0, 4'b1110};
   localparam logic [21:0] TRP    = {3'd7, 8'b0000_0000, 2'd0, 2'd0, 3'd0, 4'b0001};

   function automatic logic [21:0] outs();
      return {bus.state, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write,
              bus.mdr_write, bus.pc_write, bus.pc_src, bus.oldpc_write,
              bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
              bus.reg_write, bus.mem_to_reg, bus.retire, bus.trap};
   endfunction

   // Asserts reset, checks outputs drop asynchronously, releases on a falling edge
   // and leaves the bench in the first FETCH cycle.
   task automatic test_reset();
      rst_n         = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      total++;
      if (outs() !== 22'd0) begin
         bad++;
         $display("FAIL reset_active got=%h exp=%h", outs(), 22'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (outs() !== F_WAIT) begin
         bad++;
         $display("FAIL reset_release got=%h exp=%h", outs(), F_WAIT);
      end
      $display("reset: outputs cleared, mem_req up after release");
   endtask

   task automatic test_addi();
      logic [21:0] ev [4] = '{F_RDY, DEC, EX_IMM, WB_ALU};
      bus.instr = 32'h0050_0093;
      bus.zero  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bus.mem_ready = 1'b1;
         #1;
         total++;
         if (outs() !== ev[c]) begin
            bad++;
            $display("FAIL addi cyc%0d got=%h exp=%h", c, outs(), ev[c]);
         end
         @(negedge clk); #1;
      end
      $display("addi x1,x0,5: 4 cycles");
   endtask

   task automatic test_load_wait();
      logic [21:0] ev  [8] = '{F_RDY, DEC, EX_IMM, M_WAIT, M_WAIT, M_WAIT, M_LD, WB_LD};
      bit          rdy [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      bus.instr = 32'h0000_A103;
      for (int c = 0; c < 8; c++) begin
         bus.mem_ready = rdy[c];
         #1;
         total++;
         if (outs() !== ev[c]) begin
            bad++;
            $display("FAIL lw_wait cyc%0d got=%h exp=%h", c, outs(), ev[c]);
         end
         @(negedge clk); #1;
      end
      $display("lw x2,0(x1) with 3 wait cycles: 8 cycles");
   endtask

   task automatic test_branch();
      logic [21:0] ev_t [3] = '{F_RDY, DEC, EX_BT};
      logic [21:0] ev_n [3] = '{F_RDY, DEC, EX_BN};
      bus.instr = 32'h0020_9463;
      bus.zero  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.mem_ready = 1'b1;
         #1;
         total++;
         if (outs() !== ev_t[c]) begin
            bad++;
            $display("FAIL bne_taken cyc%0d got=%h exp=%h", c, outs(), ev_t[c]);
         end
         @(negedge clk); #1;
      end
      $display("bne zero=0: taken, 3 cycles");
      bus.zero = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.mem_ready = 1'b1;
         #1;
         total++;
         if (outs() !== ev_n[c]) begin
            bad++;
            $display("FAIL bne_not_taken cyc%0d got=%h exp=%h", c, outs(), ev_n[c]);
         end
         @(negedge clk); #1;
      end
      bus.zero = 1'b0;
      $display("bne zero=1: not taken, 3 cycles");
   endtask

   task automatic test_store_xor();
      logic [21:0] ev_s  [5] = '{F_RDY, DEC, EX_IMM, M_STW, M_ST};
      bit          rdy_s [5] = '{1, 1, 1, 0, 1};
      logic [21:0] ev_x  [4] = '{F_RDY, DEC, EX_XOR, WB_ALU};
      bus.instr = 32'h0020_A223;
      for (int c = 0; c < 5; c++) begin
         bus.mem_ready = rdy_s[c];
         #1;
         total++;
         if (outs() !== ev_s[c]) begin
            bad++;
            $display("FAIL sw cyc%0d got=%h exp=%h", c, outs(), ev_s[c]);
         end
         @(negedge clk); #1;
      end
      $display("sw x2,4(x1) with 1 wait cycle: 5 cycles");
      bus.instr = 32'h0020_C1B3;
      for (int c = 0; c < 4; c++) begin
         bus.mem_ready = 1'b1;
         #1;
         total++;
         if (outs() !== ev_x[c]) begin
            bad++;
            $display("FAIL xor cyc%0d got=%h exp=%h", c, outs(), ev_x[c]);
         end
         @(negedge clk); #1;
      end
      $display("xor x3,x1,x2: 4 cycles");
   endtask

   task automatic test_trap(input logic [31:0] ins, input string tag);
      logic [21:0] ev [5] = '{F_RDY, DEC, TRP, TRP, TRP};
      bus.instr = ins;
      for (int c = 0; c < 5; c++) begin
         bus.mem_ready = 1'b1;
         bus.zero      = c[0];
         #1;
         total++;
         if (outs() !== ev[c]) begin
            bad++;
            $display("FAIL %s cyc%0d got=%h exp=%h", tag, c, outs(), ev[c]);
         end
         @(negedge clk); #1;
      end
      bus.zero = 1'b0;
      $display("%s: trapped after DECODE and held", tag);
      test_reset();
   endtask

   task automatic test_timeout();
      logic [21:0] ev1  [6] = '{F_WAIT, F_WAIT, F_WAIT, F_WAIT, TRP, TRP};
      logic [21:0] ev2  [7] = '{F_WAIT, F_WAIT, F_WAIT, F_RDY, DEC, EX_IMM, WB_ALU};
      bit          rdy2 [7] = '{0, 0, 0, 1, 1, 1, 1};
      logic [21:0] ev3  [4] = '{F_RDY, DEC, EX_IMM, M_WAIT};
      bit          rdy3 [4] = '{1, 1, 1, 0};
      bus.instr = 32'h0050_0093;
      for (int c = 0; c < 6; c++) begin
         bus.mem_ready = 1'b0;
         #1;
         total++;
         if (outs() !== ev1[c]) begin
            bad++;
            $display("FAIL fetch_timeout cyc%0d got=%h exp=%h", c, outs(), ev1[c]);
         end
         @(negedge clk); #1;
      end
      $display("fetch timeout: TRAP after 4 wait cycles");
      test_reset();
      for (int c = 0; c < 7; c++) begin
         bus.mem_ready = rdy2[c];
         #1;
         total++;
         if (outs() !== ev2[c]) begin
            bad++;
            $display("FAIL fetch_ready_last cyc%0d got=%h exp=%h", c, outs(), ev2[c]);
         end
         @(negedge clk); #1;
      end
      $display("fetch ready on 4th cycle: completes normally");
      bus.instr = 32'h0000_A103;
      for (int c = 0; c < 4; c++) begin
         bus.mem_ready = rdy3[c];
         #1;
         total++;
         if (outs() !== ev3[c]) begin
            bad++;
            $display("FAIL mem_abort cyc%0d got=%h exp=%h", c, outs(), ev3[c]);
         end
         @(negedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ((bus.mem_req !== 1'b0) || (bus.state !== 3'd0)) begin
         bad++;
         $display("FAIL mem_abort_reset got req=%b state=%0d exp req=0 state=0",
                  bus.mem_req, bus.state);
      end
      $display("reset mid-MEM: request dropped");
      test_reset();
   endtask

   initial begin
      bus.instr     = 32'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      test_reset();
      test_addi();
      test_load_wait();
      test_branch();
      test_store_xor();
      test_trap(32'h0000_007F, "illegal_opcode");
      test_trap(32'h0020_8463, "branch_funct3_000");
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
